// File: rtl/sprite_mixer.sv
// Two-stage sprite compositor: merges player/bullet/enemy layers over a background
// and counts bullet/enemy and player/enemy overlaps per frame, publishing at calc.
module sprite_mixer #(
  parameter int          H_ACTIVE  = 1920,
  parameter int          V_ACTIVE  = 1080,
  parameter logic [23:0] BLANK_RGB = 24'h000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] display_col,
  input  logic [10:0] display_row,
  input  logic        calc,
  input  logic [24:0] bullet_color,
  input  logic [24:0] player_color,
  input  logic [24:0] enemy_color,
  input  logic [23:0] background,
  output logic [23:0] pixel_rgb,
  output logic [7:0]  bullet_hits,
  output logic [11:0] hit_col,
  output logic [10:0] hit_row,
  output logic        player_hit,
  output logic        frame_done
);

  localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, ACTIVE, PUBLISH, BLANK} state_t;

  state_t      state_reg, state_next;
  logic [11:0] s1_col_reg;
  logic [10:0] s1_row_reg;
  logic        s1_calc_reg, s1_calc_prev_reg;
  logic [23:0] s1_bg_reg;
  logic [24:0] layer_in [3];   // index 0 has the highest priority
  logic [24:0] s1_layer [3];
  logic        s1_vis;
  logic [23:0] pixel_next;

  logic [7:0]  acc_hits_reg;
  logic [11:0] acc_col_reg;
  logic [10:0] acc_row_reg;
  logic        acc_player_reg;
  logic        acc_en, bullet_enemy, player_enemy;

  assign layer_in[0] = player_color;
  assign layer_in[1] = bullet_color;
  assign layer_in[2] = enemy_color;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_layer
      logic [24:0] layer_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) layer_reg <= '0;
        else       layer_reg <= layer_in[gi];
      end
      assign s1_layer[gi] = layer_reg;
    end
  endgenerate

  // calc history resets high so a fresh calc-low period is needed before a frame counts
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_col_reg       <= '0;
      s1_row_reg       <= '0;
      s1_calc_reg      <= 1'b1;
      s1_calc_prev_reg <= 1'b1;
      s1_bg_reg        <= '0;
    end else begin
      s1_col_reg       <= display_col;
      s1_row_reg       <= display_row;
      s1_calc_reg      <= calc;
      s1_calc_prev_reg <= s1_calc_reg;
      s1_bg_reg        <= background;
    end
  end

  assign s1_vis = !s1_calc_reg && (s1_col_reg < H_LIM) && (s1_row_reg < V_LIM);

  always_comb begin
    pixel_next = s1_bg_reg;
    for (int i = 2; i >= 0; i--) begin
      if (s1_layer[i][0]) pixel_next = s1_layer[i][24:1];
    end
    if (!s1_vis) pixel_next = BLANK_RGB;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!s1_calc_reg) state_next = ACTIVE;
      ACTIVE:  if (s1_calc_reg && !s1_calc_prev_reg) state_next = PUBLISH;
      PUBLISH: state_next = BLANK;
      BLANK:   if (!s1_calc_reg) state_next = ACTIVE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  assign acc_en       = (state_reg == ACTIVE) && s1_vis;
  assign bullet_enemy = s1_layer[1][0] && s1_layer[2][0];
  assign player_enemy = s1_layer[0][0] && s1_layer[2][0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_hits_reg   <= '0;
      acc_col_reg    <= '0;
      acc_row_reg    <= '0;
      acc_player_reg <= 1'b0;
    end else if (state_reg == PUBLISH) begin
      acc_hits_reg   <= '0;
      acc_col_reg    <= '0;
      acc_row_reg    <= '0;
      acc_player_reg <= 1'b0;
    end else if (acc_en) begin
      if (bullet_enemy) begin
        if (acc_hits_reg == 8'd0) begin
          acc_col_reg <= s1_col_reg;
          acc_row_reg <= s1_row_reg;
        end
        if (acc_hits_reg != 8'hFF) acc_hits_reg <= acc_hits_reg + 8'd1;
      end
      if (player_enemy) acc_player_reg <= 1'b1;
    end
  end

  // Results load on the edge entering PUBLISH so frame_done and the data align
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_rgb   <= BLANK_RGB;
      bullet_hits <= '0;
      hit_col     <= '0;
      hit_row     <= '0;
      player_hit  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      pixel_rgb  <= pixel_next;
      frame_done <= (state_next == PUBLISH);
      if (state_next == PUBLISH) begin
        bullet_hits <= acc_hits_reg;
        hit_col     <= acc_col_reg;
        hit_row     <= acc_row_reg;
        player_hit  <= acc_player_reg;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mixer.sv
// Directed bench for sprite_mixer: stimulus pushes expected pixels and frame results
// into queues; a negedge monitor pops and compares when the DUT presents them.
module tb_sprite_mixer;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        calc;
  logic [24:0] bullet_color, player_color, enemy_color;
  logic [23:0] background;
  logic [23:0] pixel_rgb;
  logic [7:0]  bullet_hits;
  logic [11:0] hit_col;
  logic [10:0] hit_row;
  logic        player_hit;
  logic        frame_done;

  sprite_mixer dut (
    .clock(clock), .reset(reset),
    .display_col(display_col), .display_row(display_row), .calc(calc),
    .bullet_color(bullet_color), .player_color(player_color), .enemy_color(enemy_color),
    .background(background), .pixel_rgb(pixel_rgb), .bullet_hits(bullet_hits),
    .hit_col(hit_col), .hit_row(hit_row), .player_hit(player_hit), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  localparam logic [23:0] P_RGB = 24'hAA1111;
  localparam logic [23:0] B_RGB = 24'h22BB22;
  localparam logic [23:0] E_RGB = 24'h3333CC;
  localparam logic [23:0] BG    = 24'h0F0F0F;
  localparam logic [24:0] PL    = {P_RGB, 1'b1};
  localparam logic [24:0] BU    = {B_RGB, 1'b1};
  localparam logic [24:0] EN    = {E_RGB, 1'b1};
  localparam logic [24:0] NONE  = {24'h555555, 1'b0};

  typedef struct {
    logic [7:0]  hits;
    logic [11:0] col;
    logic [10:0] row;
    logic        ph;
    int          cyc;
  } res_t;

  res_t        res_q[$];
  logic [23:0] pix_q[$];
  int total = 0;
  int bad   = 0;
  int cycle = 0;
  logic tag_in = 1'b0, tag1 = 1'b0, tag2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clock) begin
    cycle++;
    tag2 <= tag1;
    tag1 <= tag_in;
  end

  // Monitor: pixels are due two edges after issue; results whenever frame_done is high
  always @(negedge clock) begin
    if (tag2) begin
      if (pix_q.size() == 0) check("pixel_queue_underflow", 1, 0);
      else begin
        logic [23:0] e;
        e = pix_q.pop_front();
        $display("pixel  cycle=%0d rgb=%06h exp=%06h", cycle, pixel_rgb, e);
        check("pixel_rgb", pixel_rgb, e);
      end
    end
    if (frame_done) begin
      if (res_q.size() == 0) check("unexpected_frame_done", 1, 0);
      else begin
        res_t r;
        r = res_q.pop_front();
        $display("frame  cycle=%0d hits=%0d col=%0d row=%0d player=%0d", cycle,
                 bullet_hits, hit_col, hit_row, player_hit);
        check("frame_done_latency", cycle, r.cyc);
        check("bullet_hits", bullet_hits, r.hits);
        check("hit_col", hit_col, r.col);
        check("hit_row", hit_row, r.row);
        check("player_hit", player_hit, r.ph);
      end
    end
  end

  task automatic step(input logic [11:0] col, input logic [10:0] row, input logic c,
                      input logic [24:0] b, input logic [24:0] p, input logic [24:0] e,
                      input logic chk, input logic [23:0] exp);
    @(negedge clock);
    display_col  = col;
    display_row  = row;
    calc         = c;
    bullet_color = b;
    player_color = p;
    enemy_color  = e;
    background   = BG;
    tag_in       = chk;
    if (chk) pix_q.push_back(exp);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) step(12'd1950, 11'd0, 1'b0, NONE, NONE, NONE, 1'b0, 24'h0);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(12'd1950, 11'd1100, 1'b1, NONE, NONE, NONE, 1'b0, 24'h0);
  endtask

  // Raise calc and expect the frame results two edges later
  task automatic rise(input logic [7:0] h, input logic [11:0] c, input logic [10:0] r,
                      input logic ph);
    res_t x;
    step(12'd0, 11'd0, 1'b1, NONE, NONE, NONE, 1'b1, 24'h000000);
    x.hits = h; x.col = c; x.row = r; x.ph = ph; x.cyc = cycle + 2;
    res_q.push_back(x);
  endtask

  initial begin
    reset = 1'b1; calc = 1'b0; display_col = '0; display_row = '0;
    bullet_color = '0; player_color = '0; enemy_color = '0; background = '0;
    repeat (3) @(negedge clock);
    check("rst_pixel_rgb", pixel_rgb, 24'h000000);
    check("rst_bullet_hits", bullet_hits, 0);
    check("rst_hit_col", hit_col, 0);
    check("rst_hit_row", hit_row, 0);
    check("rst_player_hit", player_hit, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;

    // Frame 0: layer priority and blanking
    fill(2);
    step(12'd10, 11'd10, 1'b0, BU, PL, EN, 1'b1, P_RGB);
    step(12'd11, 11'd10, 1'b0, BU, NONE, EN, 1'b1, B_RGB);
    step(12'd12, 11'd10, 1'b0, NONE, NONE, EN, 1'b1, E_RGB);
    step(12'd13, 11'd10, 1'b0, NONE, NONE, NONE, 1'b1, BG);
    step(12'd1920, 11'd5, 1'b0, BU, PL, EN, 1'b1, 24'h000000);
    begin
      res_t x;
      step(12'd20, 11'd10, 1'b1, BU, PL, EN, 1'b1, 24'h000000);
      x.hits = 8'd2; x.col = 12'd10; x.row = 11'd10; x.ph = 1'b1; x.cyc = cycle + 2;
      res_q.push_back(x);
    end
    hold(3);

    // Frame 1: three consecutive bullet/enemy overlaps
    fill(2);
    for (int i = 0; i < 3; i++) step(12'(100 + i), 11'd200, 1'b0, BU, NONE, EN, 1'b1, B_RGB);
    fill(1);
    rise(8'd3, 12'd100, 11'd200, 1'b0);
    hold(3);

    // Frame 2: async reset mid-frame discards the partial count
    fill(2);
    for (int i = 0; i < 5; i++) step(12'(40 + i), 11'd30, 1'b0, BU, NONE, EN, 1'b0, 24'h0);
    #2 reset = 1'b1;
    calc = 1'b1;
    bullet_color = NONE; enemy_color = NONE;
    #1;
    check("async_pixel_rgb", pixel_rgb, 24'h000000);
    check("async_bullet_hits", bullet_hits, 0);
    check("async_hit_col", hit_col, 0);
    check("async_hit_row", hit_row, 0);
    check("async_player_hit", player_hit, 0);
    check("async_frame_done", frame_done, 0);
    #1 reset = 1'b0;
    hold(5);
    fill(2);
    step(12'd33, 11'd44, 1'b0, BU, NONE, EN, 1'b1, B_RGB);
    fill(1);
    rise(8'd1, 12'd33, 11'd44, 1'b0);
    hold(3);

    // Frame 3: saturation at 255 keeps the first capture
    fill(2);
    for (int i = 0; i < 300; i++) step(12'(50 + i), 11'd7, 1'b0, BU, NONE, EN, 1'b0, 24'h0);
    rise(8'd255, 12'd50, 11'd7, 1'b0);
    hold(3);

    // Frame 4: clean frame still publishes
    fill(3);
    rise(8'd0, 12'd0, 11'd0, 1'b0);
    hold(3);

    // Frame 5: player/enemy overlap, then a clean frame
    fill(2);
    step(12'd5, 11'd5, 1'b0, NONE, PL, EN, 1'b1, P_RGB);
    fill(1);
    rise(8'd0, 12'd0, 11'd0, 1'b1);
    hold(3);
    fill(2);
    rise(8'd0, 12'd0, 11'd0, 1'b0);
    hold(3);

    // Frame 7: single-cycle calc glitch, next frame starts fresh
    fill(2);
    step(12'd60, 11'd61, 1'b0, BU, NONE, EN, 1'b0, 24'h0);
    fill(1);
    rise(8'd1, 12'd60, 11'd61, 1'b0);
    fill(2);
    step(12'd70, 11'd71, 1'b0, BU, NONE, EN, 1'b0, 24'h0);
    step(12'd71, 11'd71, 1'b0, BU, NONE, EN, 1'b0, 24'h0);
    fill(1);
    rise(8'd2, 12'd70, 11'd71, 1'b0);
    hold(3);

    repeat (4) @(negedge clock);
    check("pending_results", res_q.size(), 0);
    check("pending_pixels", pix_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
